// File: rtl/scr_tx_ctrl_pkg.sv
// Shared types and constants for the scrambler transmit controller.
package scr_tx_ctrl_pkg;

    localparam int WORD_W    = 8;
    localparam int RSD_CNT_W = 16;
    localparam int BIT_CNT_W = $clog2(WORD_W);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_e;

    // One queued word plus its "start from SEED" sideband flag.
    typedef struct packed {
        logic              scr_rst;
        logic [WORD_W-1:0] data;
    } hold_word_t;

    // Reseed counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [RSD_CNT_W-1:0] rsd_sat_inc(input logic [RSD_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/scr_tx_ctrl_hold.sv
// Single-entry hold register with valid/ready handshake in front of the
// serializer. Flushed whenever the lane is disabled.
module scr_tx_hold
    import scr_tx_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              lane_en_i,
    input  logic              in_valid_i,
    input  logic [WORD_W-1:0] in_data_i,
    input  logic              in_scr_rst_i,
    input  logic              pop_i,
    output logic              in_ready_o,
    output logic              full_o,
    output hold_word_t        word_o
);

    logic       full_q, full_d;
    hold_word_t word_q, word_d;
    logic       ready_ok_q;
    logic       push;

    // ready_ok_q keeps in_ready low for the cycle right after reset.
    assign in_ready_o = lane_en_i & ~full_q & ready_ok_q;
    assign push       = in_valid_i & in_ready_o;
    assign full_o     = full_q;
    assign word_o     = word_q;

    // Next-state for occupancy and stored word: flush, consume, then capture.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        full_d = full_q;
        word_d = word_q;
        if (!lane_en_i) begin
            full_d = 1'b0;
            word_d = '0;
        end else begin
            if (pop_i) begin
                full_d = 1'b0;
            end
            if (push) begin
                full_d = 1'b1;
                word_d = '{scr_rst: in_scr_rst_i, data: in_data_i};
            end
        end
    end

    // Hold register state update.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            full_q     <= 1'b0;
            // NOTE: the stored word is cleared too, so nothing stale is visible after reset.
            word_q     <= '0;
            ready_ok_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            word_q     <= word_d;
            ready_ok_q <= 1'b1;
        end
    end

endmodule

// File: rtl/scr_tx_ctrl.sv
// Scrambler transmit controller: serializes 8-bit words LSB first into an
// external scrambler, chaining words without gaps and requesting reseeds.
module scr_tx_ctrl
    import scr_tx_ctrl_pkg::*;
#(
    parameter int unsigned RESEED_PERIOD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lane_en,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_scr_rst,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              scr_data_in,
    output logic              scr_enable,
    output logic              scr_rst_o,
    output logic              busy,
    output logic              underrun
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT    = BIT_CNT_W'(WORD_W - 1);
    localparam logic [RSD_CNT_W-1:0] RESEED_VAL  = RSD_CNT_W'(RESEED_PERIOD);
    localparam bit                   AUTO_RESEED = (RESEED_PERIOD != 0);

    tx_state_e              state_q, state_d;
    logic [WORD_W-1:0]      shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [RSD_CNT_W-1:0]   rsd_cnt_q, rsd_cnt_d;
    logic                   hold_full;
    hold_word_t             hold_word;
    logic                   pop;
    logic                   running;
    logic                   last_bit;
    logic                   reseed_due;

    scr_tx_hold u_hold (
        .clk          (clk),
        .rst          (rst),
        .lane_en_i    (lane_en),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_scr_rst_i (in_scr_rst),
        .pop_i        (pop),
        .in_ready_o   (in_ready),
        .full_o       (hold_full),
        .word_o       (hold_word)
    );

    assign running    = (state_q == ST_RUN);
    assign last_bit   = running && (bit_cnt_q == LAST_BIT);
    assign reseed_due = hold_word.scr_rst | (AUTO_RESEED && (rsd_cnt_q == RESEED_VAL));

    // Outputs decode registered state only.
    assign scr_enable  = running;
    assign scr_data_in = running & shift_q[bit_cnt_q];
    assign scr_rst_o   = last_bit & hold_full & reseed_due;
    assign underrun    = last_bit & ~hold_full;
    assign busy        = running | hold_full;

    // Next-state: word start from IDLE, bit stepping, chaining and reseed counting.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        rsd_cnt_d = rsd_cnt_q;
        pop       = 1'b0;
        if (!lane_en) begin
            state_d   = ST_IDLE;
            shift_d   = '0;
            bit_cnt_d = '0;
            rsd_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hold_full) begin
                        pop       = 1'b1;
                        shift_d   = hold_word.data;
                        bit_cnt_d = '0;
                        rsd_cnt_d = rsd_sat_inc('0);
                        state_d   = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (hold_full) begin
                            // Seamless chaining; a reseed restarts the count with this word.
                            pop       = 1'b1;
                            shift_d   = hold_word.data;
                            bit_cnt_d = '0;
                            rsd_cnt_d = rsd_sat_inc(reseed_due ? '0 : rsd_cnt_q);
                        end else begin
                            state_d   = ST_IDLE;
                            shift_d   = '0;
                            bit_cnt_d = '0;
                            rsd_cnt_d = '0;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            rsd_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            rsd_cnt_q <= rsd_cnt_d;
        end
    end

endmodule

// File: doc/scr_tx_ctrl.md
SCR_TX_CTRL -- requirements
Module: scr_tx_ctrl

Interface
REQ-001 Parameter RESEED_PERIOD, default 0: words between automatic scrambler reseeds; 0 disables auto reseed; legal range 0..65535.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 lane_en  in  1  lane transmit enable.
REQ-005 in_data  in  8  parallel word to transmit, serialized LSB first.
REQ-006 in_scr_rst  in  1  sideband: the word on in_data starts from scrambler SEED.
REQ-007 in_valid  in  1  producer holds word valid.
REQ-008 in_ready  out  1  block can accept a word this cycle.
REQ-009 scr_data_in  out  1  serial bit to scrambler data_in.
REQ-010 scr_enable  out  1  to scrambler enable.
REQ-011 scr_rst_o  out  1  to scrambler scr_rst.
REQ-012 busy  out  1  high while in state RUN or while the hold register is occupied.
REQ-013 underrun  out  1  one-cycle pulse when a word ends with no successor.

Function
REQ-014 Transfer occurs on a cycle with in_valid=1 and in_ready=1; in_data and in_scr_rst are captured into the hold register.
REQ-015 in_ready = lane_en AND hold register empty; no combinational path from in_valid to in_ready.
REQ-016 The state machine has two states: IDLE and RUN.
REQ-017 IDLE: scr_enable=0, scr_rst_o=0, scr_data_in=0; when hold is full and lane_en=1, move hold to the shift register, set bit_cnt=0, and go to RUN.
REQ-018 RUN: scr_enable=1; scr_data_in=shift[bit_cnt]; bit_cnt increments 0..7.
REQ-019 Latency: the word accepted on cycle T drives its bit0 on scr_data_in during cycle T+2 when the block was IDLE with hold empty.
REQ-020 At bit_cnt=7 with hold full: load the next word, wrap bit_cnt to 0, stay in RUN; there is no idle gap between words.
REQ-021 At bit_cnt=7 with hold empty: go to IDLE and pulse underrun in that cycle; the scrambler reloads SEED through enable low.
REQ-022 The reseed counter (16 bit) counts words started in RUN since the last reseed; the first word after IDLE counts as 1.
REQ-023 reseed_due = hold.scr_rst OR (RESEED_PERIOD != 0 AND reseed counter = RESEED_PERIOD).
REQ-024 scr_rst_o = RUN AND bit_cnt=7 AND hold full AND reseed_due; the following word therefore begins from SEED.
REQ-025 The reseed counter clears to 0 on any reseed, on an IDLE entry and on lane_en low; it saturates and never wraps.
REQ-026 An in_scr_rst flag on the first word after IDLE has no further effect, because SEED is already loaded.
REQ-027 lane_en low in any state: next cycle go to IDLE, flush the hold and shift registers, clear bit_cnt, drive scr_enable=0, no underrun pulse.
REQ-028 A hold-register load and a shift consumption in the same cycle are both honoured; hold is never overwritten while full.
REQ-029 All outputs are driven from registers or from register-only decode; no input-to-output combinational path.

Reset
REQ-030 rst=1 at a rising edge: state=IDLE; hold and shift registers, bit_cnt and reseed counter cleared; in_ready=0, scr_enable=0, scr_rst_o=0, scr_data_in=0, busy=0, underrun=0.
REQ-031 rst mid-word aborts the word with no partial continuation; operation resumes at most one cycle after rst deasserts.

Structure
REQ-032 The shared package holds the IDLE/RUN state enum, the word-width constant 8, and the reseed-counter width constant 16.
REQ-033 The hold register with its handshake is a natural sub-module named scr_tx_hold; the scrambler is instantiated by the parent, not inside this block.

Verification
REQ-034 Send word 0xA5 from IDLE -> scr_enable high for exactly 8 cycles starting at T+2; scr_data_in=1,0,1,0,0,1,0,1; scr_rst_o never asserts; underrun pulses at bit 7.
REQ-035 Send 3 words back-to-back -> 24 contiguous scr_enable cycles and a single underrun pulse after the third word.
REQ-036 Send 2 words with in_scr_rst=1 on word 2 -> scr_rst_o high exactly on bit 7 of word 1; a scrambler model shows word 2 scrambled from SEED 0x1FEEDD.
REQ-037 Set RESEED_PERIOD=4 and stream 10 words -> scr_rst_o on the last bit of words 4 and 8 only.
REQ-038 Drop lane_en at bit 3 of a word with hold full -> scr_enable=0 next cycle, busy=0, no underrun pulse, and the next accepted word starts at bit0.
REQ-039 Assert rst for 1 cycle mid-stream -> all outputs match their reset values on the next cycle, and a new word afterwards behaves as in REQ-034.
